// File: rtl/delay_pkg.sv
// Shared types and constants for the delay tap sequencer.
// Optional DELAY_MEM_CLEAR_EN build uses the CLEAR state declared here.
package delay_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 15;
    localparam int MAX_TAPS   = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        RD3,
        FIN,
        CLEAR
    } state_t;

    // Largest D for which the 3D tap can never land on the write address.
    function automatic int unsigned max_delay(input int unsigned addr_w);
        return ((32'd1 << addr_w) - 32'd1) / 32'd3;
    endfunction

endpackage

// File: rtl/delay_addr_gen.sv
// Combinational tap address generator: modulo read address for tap k and
// whether that tap must be forced to zero.
module delay_addr_gen
    import delay_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] delay,
    input  logic [1:0]        tap_idx,
    input  logic [1:0]        n_taps,
    input  logic [ADDR_W:0]   fill_cnt,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              masked
);

    logic [ADDR_W+1:0] offset;

    assign offset  = {{ADDR_W{1'b0}}, tap_idx} * {2'b00, delay};
    // The subtraction wraps naturally at ADDR_W bits, giving the modulo address.
    assign rd_addr = wr_ptr - offset[ADDR_W-1:0];
    assign masked  = (tap_idx > n_taps) || (delay == '0) || ({1'b0, fill_cnt} < offset);

endmodule

// File: rtl/delay_tap_sequencer.sv
// One write plus three tap reads per sample through a single RAM port.
// Define DELAY_MEM_CLEAR_EN to zero the whole delay line after every reset.
module delay_tap_sequencer
    import delay_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [31:0]       delay_time,
    input  logic [31:0]       delay_repeat_time,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tap_n_1,
    output logic [DATA_W-1:0] tap_n_2,
    output logic [DATA_W-1:0] tap_n_3,
    output logic              taps_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [31:0]     MAX_D    = 32'(max_delay(ADDR_W));
    localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   fill_cnt;
    logic [ADDR_W-1:0] d_in, d_lat;
    logic [1:0]        n_in, n_lat;
    logic [DATA_W-1:0] tap1_r, tap2_r;
    logic [ADDR_W-1:0] rd_addr [1:3];
    logic [3:1]        tap_mask;
`ifdef DELAY_MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_ptr;
`endif

    assign d_in = (delay_time > MAX_D) ? MAX_D[ADDR_W-1:0] : delay_time[ADDR_W-1:0];
    assign n_in = (delay_repeat_time > 32'(MAX_TAPS)) ? 2'(MAX_TAPS) : delay_repeat_time[1:0];

    for (genvar k = 1; k <= MAX_TAPS; k++) begin : g_tap
        delay_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
            .wr_ptr  (wr_ptr),
            .delay   (d_lat),
            .tap_idx (2'(k)),
            .n_taps  (n_lat),
            .fill_cnt(fill_cnt),
            .rd_addr (rd_addr[k]),
            .masked  (tap_mask[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef DELAY_MEM_CLEAR_EN
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_ptr <= '0;
`else
            state   <= IDLE;
            busy    <= 1'b0;
`endif
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            d_lat      <= '0;
            n_lat      <= '0;
            tap1_r     <= '0;
            tap2_r     <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            tap_n_1    <= '0;
            tap_n_2    <= '0;
            tap_n_3    <= '0;
            taps_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; a state that needs them overrides below.
            mem_we     <= 1'b0;
            taps_valid <= 1'b0;

            if (sample_valid && state != IDLE && state != CLEAR) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        d_lat     <= d_in;
                        n_lat     <= n_in;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= sample_in;
                        busy      <= 1'b1;
                        state     <= WR;
                    end
                end
                WR: begin
                    mem_addr <= rd_addr[1];
                    state    <= RD1;
                end
                RD1: begin
                    mem_addr <= rd_addr[2];
                    state    <= RD2;
                end
                RD2: begin
                    tap1_r   <= mem_rdata;
                    mem_addr <= rd_addr[3];
                    state    <= RD3;
                end
                RD3: begin
                    tap2_r <= mem_rdata;
                    state  <= FIN;
                end
                FIN: begin
                    tap_n_1    <= tap_mask[1] ? '0 : tap1_r;
                    tap_n_2    <= tap_mask[2] ? '0 : tap2_r;
                    tap_n_3    <= tap_mask[3] ? '0 : mem_rdata;
                    taps_valid <= 1'b1;
                    wr_ptr     <= wr_ptr + 1'b1;
                    if (fill_cnt != FILL_MAX) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`ifdef DELAY_MEM_CLEAR_EN
                CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= clr_ptr;
                    mem_wdata <= '0;
                    clr_ptr   <= clr_ptr + 1'b1;
                    if (clr_ptr == '1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_sequencer.sv
// Randomized bench for delay_tap_sequencer against a sample-history model.
// Also covers the DELAY_MEM_CLEAR_EN build when that macro is defined.
module tb_delay_tap_sequencer;
    import delay_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int MAXD  = int'(max_delay(AW));

    logic          clk, rst;
    logic          sample_valid;
    logic [DW-1:0] sample_in;
    logic [31:0]   delay_time, delay_repeat_time;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] tap_n_1, tap_n_2, tap_n_3;
    logic          taps_valid, busy, overrun;

    delay_tap_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .delay_time       (delay_time),
        .delay_repeat_time(delay_repeat_time),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .tap_n_1          (tap_n_1),
        .tap_n_2          (tap_n_2),
        .tap_n_3          (tap_n_3),
        .taps_valid       (taps_valid),
        .busy             (busy),
        .overrun          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency, preloaded with garbage.
    logic [DW-1:0] ram [DEPTH];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            acc;
        int            waddr;
        logic [DW-1:0] data;
        int            ra1, ra2, ra3;
        logic [DW-1:0] t1, t2, t3;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] hist[$];
    int            cyc = 0;
    int            nsamp = 0;
    int            last_acc = -100;
    bit            m_ovr = 1'b0;
    bit            model_clearing = 1'b0;
    bit            check_en = 1'b1;

    function automatic logic [DW-1:0] tap_val(int k, int nc, int dc, int fill, int n);
        if (k <= nc && dc > 0 && k * dc <= fill) return hist[n - k * dc];
        return '0;
    endfunction

    function automatic int mod_addr(int a);
        return (a + 4 * DEPTH) % DEPTH;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                hist.delete();
                nsamp    = 0;
                m_ovr    = 1'b0;
                last_acc = -100;
            end else if (sample_valid && !model_clearing) begin
                if (cyc - last_acc >= 6) begin
                    exp_t e;
                    int wr, fill, dc, nc;
                    wr   = nsamp % DEPTH;
                    fill = (nsamp < DEPTH) ? nsamp : DEPTH;
                    dc   = (delay_time > 32'(MAXD)) ? MAXD : int'(delay_time);
                    nc   = (delay_repeat_time > 32'd3) ? 3 : int'(delay_repeat_time);
                    e.acc   = cyc;
                    e.waddr = wr;
                    e.data  = sample_in;
                    e.ra1   = mod_addr(wr - dc);
                    e.ra2   = mod_addr(wr - 2 * dc);
                    e.ra3   = mod_addr(wr - 3 * dc);
                    e.t1    = tap_val(1, nc, dc, fill, nsamp);
                    e.t2    = tap_val(2, nc, dc, fill, nsamp);
                    e.t3    = tap_val(3, nc, dc, fill, nsamp);
                    q.push_back(e);
                    hist.push_back(sample_in);
                    nsamp++;
                    last_acc = cyc;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && check_en) begin
                exp_t h;
                bit   have;
                have = q.size() > 0;
                if (have) h = q[0];
                check("mem_we", mem_we, have && cyc == h.acc);
                if (have && cyc == h.acc) begin
                    check("wr_addr", mem_addr, h.waddr);
                    check("wr_data", mem_wdata, h.data);
                end
                if (have && cyc == h.acc + 1) check("rd_addr1", mem_addr, h.ra1);
                if (have && cyc == h.acc + 2) check("rd_addr2", mem_addr, h.ra2);
                if (have && cyc == h.acc + 3) check("rd_addr3", mem_addr, h.ra3);
                check("busy", busy, have && cyc >= h.acc && cyc <= h.acc + 4);
                check("taps_valid", taps_valid, have && cyc == h.acc + 5);
                if (have && cyc == h.acc + 5) begin
                    check("tap_n_1", tap_n_1, h.t1);
                    check("tap_n_2", tap_n_2, h.t2);
                    check("tap_n_3", tap_n_3, h.t3);
                    void'(q.pop_front());
                end
                check("overrun", overrun, m_ovr);
            end
        end
    end

    int tv_pulses = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && taps_valid === 1'b1) tv_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    bit rand_params = 1'b0;

    function automatic logic [31:0] rand_delay();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return $urandom;
            default: return 32'($urandom_range(1, 400));
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_params) begin
                delay_time        = rand_delay();
                delay_repeat_time = 32'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] v);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (i == 40) check("wait_idle_timeout", 1, 0);
    endtask

`ifdef DELAY_MEM_CLEAR_EN
    task automatic run_clear();
        int busy_cyc, wr_cnt, bad, seen_cnt;
        bit seen [DEPTH];
        busy_cyc = 0; wr_cnt = 0; bad = 0; seen_cnt = 0;
        for (int a = 0; a < DEPTH; a++) seen[a] = 1'b0;
        model_clearing = 1'b1;
        check_en       = 1'b0;
        #1;
        for (int i = 0; i < DEPTH + 50; i++) begin
            if (busy) busy_cyc++;
            if (mem_we) begin
                wr_cnt++;
                if (mem_wdata != '0) bad++;
                seen[mem_addr] = 1'b1;
            end
            if (!busy && !mem_we) break;
            sample_valid = (i == 100);
            @(negedge clk);
            #1;
        end
        sample_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) if (seen[a]) seen_cnt++;
        check("clear_busy_cycles", busy_cyc, DEPTH);
        check("clear_write_count", wr_cnt, DEPTH);
        check("clear_addr_coverage", seen_cnt, DEPTH);
        check("clear_nonzero_writes", bad, 0);
        check("clear_overrun", overrun, 0);
        model_clearing = 1'b0;
        check_en       = 1'b1;
    endtask
`endif

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
        run_clear();
`endif
    endtask

    logic [DW-1:0] wv [1030];

    initial begin
        rst               = 1'b1;
        sample_valid      = 1'b0;
        sample_in         = '0;
        delay_time        = '0;
        delay_repeat_time = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_tap_n_1", tap_n_1, 0);
        check("rst_tap_n_2", tap_n_2, 0);
        check("rst_tap_n_3", tap_n_3, 0);
        check("rst_taps_valid", taps_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_overrun", overrun, 0);
`ifdef DELAY_MEM_CLEAR_EN
        check("rst_busy", busy, 1);
`else
        check("rst_busy", busy, 0);
`endif
        check("max_delay_15", max_delay(15), 10922);
        check("max_delay_tb", max_delay(AW), 341);

        // Single sample: every tap masked by the empty fill count.
        apply_reset();
        delay_time        = 32'd4;
        delay_repeat_time = 32'd3;
        send(16'h1234);
        #1;
        check("single_we", mem_we, 1);
        check("single_addr", mem_addr, 0);
        check("single_wdata", mem_wdata, 16'h1234);
        repeat (5) @(negedge clk);
        #1;
        check("single_taps_valid", taps_valid, 1);
        check("single_tap1", tap_n_1, 0);
        check("single_tap2", tap_n_2, 0);
        check("single_tap3", tap_n_3, 0);
        wait_idle();
        send(16'h5678);
        #1;
        check("second_wr_ptr", mem_addr, 1);
        wait_idle();

        // Ramp 1..7 every 8 cycles, D=2.
        apply_reset();
        delay_time        = 32'd2;
        delay_repeat_time = 32'd3;
        for (int v = 1; v <= 6; v++) begin
            send(DW'(v));
            idle(6);
        end
        check("ramp6_tap1", tap_n_1, 4);
        check("ramp6_tap2", tap_n_2, 2);
        check("ramp6_tap3", tap_n_3, 0);
        send(16'd7);
        idle(6);
        check("ramp7_tap1", tap_n_1, 5);
        check("ramp7_tap2", tap_n_2, 3);
        check("ramp7_tap3", tap_n_3, 1);
        delay_repeat_time = 32'd1;
        send(16'd8);
        idle(6);
        check("n1_tap1", tap_n_1, 6);
        check("n1_tap2", tap_n_2, 0);
        check("n1_tap3", tap_n_3, 0);
        delay_repeat_time = 32'd7;
        send(16'd9);
        idle(6);
        check("n7_tap1", tap_n_1, 7);
        check("n7_tap2", tap_n_2, 5);
        check("n7_tap3", tap_n_3, 3);

        // Overrun, then reset in the middle of RD2.
        apply_reset();
        delay_time        = 32'd1;
        delay_repeat_time = 32'd3;
        send(16'h0011);
        wait_idle();
        send(16'h0022);
        wait_idle();
        begin
            int p0;
            p0 = tv_pulses;
            send(16'h00AA);
            idle(1);
            send(16'h00BB);
            wait_idle();
            idle(2);
            check("overrun_set", overrun, 1);
            check("overrun_one_pulse", tv_pulses - p0, 1);
        end
        send(16'h00CC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tap1", tap_n_1, 0);
        check("midrst_tap2", tap_n_2, 0);
        check("midrst_tap3", tap_n_3, 0);
        check("midrst_taps_valid", taps_valid, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
        run_clear();
`endif

        // Wrap and clamp: more samples than the RAM depth, D far above the limit.
        apply_reset();
        delay_time        = 32'hFFFF_FFFF;
        delay_repeat_time = 32'd3;
        for (int i = 0; i < 1030; i++) begin
            wv[i] = DW'($urandom);
            send(wv[i]);
            idle(4 + $urandom_range(0, 2));
        end
        wait_idle();
        check("wrap_tap1", tap_n_1, wv[1029 - 341]);
        check("wrap_tap2", tap_n_2, wv[1029 - 682]);
        check("wrap_tap3", tap_n_3, wv[1029 - 1023]);

        // Random traffic: random spacing (drops included) and parameters changing every cycle.
        apply_reset();
        rand_params = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(DW'($urandom));
            idle($urandom_range(0, 8));
        end
        rand_params = 1'b0;
        wait_idle();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
